// File: rtl/sipo_rx_if.sv
// Serial receive link bundle: serial bit stream in, assembled word plus status out.
// Latency: none, this is wiring only.
// Backpressure: the consumer releases a held word through ack; nothing stalls the sender.
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    logic             din;
    logic             en;
    logic             sync;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             overrun;
    logic             busy;

    // Sender/consumer side: drives the serial stream and the ack.
    modport master (
        output din, en, sync, ack,
        input  q, valid, overrun, busy
    );

    // Receiver side: samples the stream and presents words.
    modport slave (
        input  din, en, sync, ack,
        output q, valid, overrun, busy
    );
endinterface

// File: rtl/sipo_rx.sv
// Deserializes a sync-aligned serial bit stream into WIDTH-bit words.
// Latency: q/valid update on the edge that samples the final bit of a word.
// Backpressure: none toward the sender; an unacknowledged word is overwritten and overrun latches.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    sipo_rx_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] q_reg;
    logic             valid_reg;
    logic             overrun_reg;

    logic [WIDTH-1:0] place;
    logic [WIDTH-1:0] word_ins;
    logic [WIDTH-1:0] word_first;
    logic             last_bit;

    // Position of the next bit within the word, plus the two candidate register images.
    always_comb begin
        place      = '0;
        word_first = '0;
        for (int i = 0; i < WIDTH; i++) begin
            place[i] = (((LSB_FIRST != 1'b0) ? i : (WIDTH - 1 - i)) == int'(count));
        end
        word_ins = (sreg & ~place) | (place & {WIDTH{bus.din}});
        if (LSB_FIRST != 1'b0) begin
            word_first[0] = bus.din;
        end else begin
            word_first[WIDTH-1] = bus.din;
        end
        last_bit = (count == CW'(WIDTH - 1));
    end

    // Receive FSM: hunting for sync, then shifting bits and emitting words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            count       <= '0;
            sreg        <= '0;
            q_reg       <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            // Ack is only meaningful while a word is held; a completion later
            // in this block re-asserts valid and wins over this clear.
            if (bus.ack && valid_reg) begin
                valid_reg <= 1'b0;
            end

            // Sync restarts alignment from either state and beats completion.
            if (bus.sync) begin
                state <= SHIFT;
                if (bus.en) begin
                    sreg  <= word_first;
                    count <= CW'(1);
                end else begin
                    sreg  <= '0;
                    count <= '0;
                end
            end else if (state == SHIFT && bus.en) begin
                if (last_bit) begin
                    q_reg     <= word_ins;
                    valid_reg <= 1'b1;
                    if (valid_reg && !bus.ack) begin
                        overrun_reg <= 1'b1;
                    end
                    sreg  <= '0;
                    count <= '0;
                end else begin
                    sreg  <= word_ins;
                    count <= count + CW'(1);
                end
            end
        end
    end

    assign bus.q       = q_reg;
    assign bus.valid   = valid_reg;
    assign bus.overrun = overrun_reg;
    assign bus.busy    = (state == SHIFT) && (count != '0);
endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(W)) bl ();
    sipo_rx_if #(.WIDTH(W)) bm ();

    sipo_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst(rst), .bus(bl.slave));
    sipo_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .bus(bm.slave));

    int errors = 0;
    int checks = 0;

    // Reference model: bits gathered since the last alignment, word built arithmetically.
    bit         m_hunt;
    bit         m_bits[$];
    logic [W-1:0] m_q_lsb, m_q_msb;
    bit         m_valid, m_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1;
        m_bits.delete();
        m_q_lsb = '0;
        m_q_msb = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit e, input bit s, input bit a);
        bit nv;
        nv = m_valid;
        if (a && m_valid) nv = 1'b0;
        if (s) begin
            m_hunt = 1'b0;
            m_bits.delete();
            if (e) m_bits.push_back(d);
        end else if (!m_hunt && e) begin
            m_bits.push_back(d);
            if (m_bits.size() == W) begin
                int wl, wm;
                wl = 0;
                wm = 0;
                for (int k = 0; k < W; k++) begin
                    wl += int'(m_bits[k]) * (2 ** k);
                    wm += int'(m_bits[k]) * (2 ** (W - 1 - k));
                end
                if (m_valid && !a) m_ovr = 1'b1;
                m_q_lsb = W'(wl);
                m_q_msb = W'(wm);
                nv = 1'b1;
                m_bits.delete();
            end
        end
        m_valid = nv;
    endtask

    function automatic bit m_busy();
        return !m_hunt && (m_bits.size() != 0);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".q_lsb"},   32'(bl.q),       32'(m_q_lsb));
        chk({tag, ".q_msb"},   32'(bm.q),       32'(m_q_msb));
        chk({tag, ".valid"},   32'(bl.valid),   32'(m_valid));
        chk({tag, ".valid_m"}, 32'(bm.valid),   32'(m_valid));
        chk({tag, ".overrun"}, 32'(bl.overrun), 32'(m_ovr));
        chk({tag, ".busy"},    32'(bl.busy),    32'(m_busy()));
    endtask

    // Drive one cycle of inputs on both DUTs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit d, input bit e, input bit s, input bit a);
        bl.din = d; bl.en = e; bl.sync = s; bl.ack = a;
        bm.din = d; bm.en = e; bm.sync = s; bm.ack = a;
        @(posedge clk);
        model_step(d, e, s, a);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends a WIDTH-bit value LSB-first; sync on the first bit if requested, ack on the last bit if requested.
    task automatic send_word(input logic [W-1:0] v, input bit with_sync, input bit ack_last);
        for (int k = 0; k < W; k++) begin
            step(v[k], 1'b1, with_sync && (k == 0), ack_last && (k == W - 1));
        end
    endtask

    typedef struct {
        bit d, e, s, a;
        logic [W-1:0] q_lsb, q_msb;
        bit v, o, b;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bl.din = 0; bl.en = 0; bl.sync = 0; bl.ack = 0;
        bm.din = 0; bm.en = 0; bm.sync = 0; bm.ack = 0;
        model_reset();
        #2;
        chk("reset.q",       32'(bl.q),       0);
        chk("reset.valid",   32'(bl.valid),   0);
        chk("reset.overrun", 32'(bl.overrun), 0);
        chk("reset.busy",    32'(bl.busy),    0);
        do_reset();

        // Basic receive of bits 1,0,1,1 then ack.
        tbl[0] = '{1, 1, 1, 0, 4'h0, 4'h0, 0, 0, 1};
        tbl[1] = '{0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1};
        tbl[2] = '{1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1};
        tbl[3] = '{1, 1, 0, 0, 4'hD, 4'hB, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 4'hD, 4'hB, 0, 0, 0};
        tbl[5] = '{1, 0, 0, 1, 4'hD, 4'hB, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].d, tbl[i].e, tbl[i].s, tbl[i].a);
            chk($sformatf("tbl%0d.q_lsb", i),   32'(bl.q),       32'(tbl[i].q_lsb));
            chk($sformatf("tbl%0d.q_msb", i),   32'(bm.q),       32'(tbl[i].q_msb));
            chk($sformatf("tbl%0d.valid", i),   32'(bl.valid),   32'(tbl[i].v));
            chk($sformatf("tbl%0d.overrun", i), 32'(bl.overrun), 32'(tbl[i].o));
            chk($sformatf("tbl%0d.busy", i),    32'(bl.busy),    32'(tbl[i].b));
            check_model($sformatf("tbl%0d.model", i));
        end

        // Hunt: bits before sync are ignored; a re-aligned word discards the partial.
        do_reset();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("hunt.busy",  32'(bl.busy),  0);
        chk("hunt.valid", 32'(bl.valid), 0);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        chk("realign.busy_partial", 32'(bl.busy), 1);
        send_word(4'h6, 1'b1, 1'b0);
        chk("realign.q_lsb", 32'(bl.q),     32'h6);
        chk("realign.q_msb", 32'(bm.q),     32'h6);
        chk("realign.valid", 32'(bl.valid), 1);
        check_model("realign.model");

        // Stall: bits 1,1,0,1 separated by 3 idle cycles each.
        do_reset();
        step(1, 1, 1, 0);
        for (int g = 0; g < 3; g++) begin
            automatic bit bv = (g == 1) ? 1'b0 : 1'b1;
            for (int i = 0; i < 3; i++) begin
                step(0, 0, 0, 0);
                chk("stall.busy_gap", 32'(bl.busy), 1);
            end
            step(bv, 1, 0, 0);
        end
        chk("stall.q_lsb", 32'(bl.q),     32'hB);
        chk("stall.q_msb", 32'(bm.q),     32'hD);
        chk("stall.valid", 32'(bl.valid), 1);

        // Simultaneous ack on second completion: no overrun.
        do_reset();
        send_word(4'h3, 1'b1, 1'b0);
        send_word(4'h5, 1'b0, 1'b1);
        chk("ackcomp.q",       32'(bl.q),       32'h5);
        chk("ackcomp.valid",   32'(bl.valid),   1);
        chk("ackcomp.overrun", 32'(bl.overrun), 0);

        // Overrun: second word completes with the first still held.
        do_reset();
        send_word(4'h3, 1'b1, 1'b0);
        chk("ovr.first_q", 32'(bl.q), 32'h3);
        send_word(4'h5, 1'b0, 1'b0);
        chk("ovr.q_lsb",   32'(bl.q),       32'h5);
        chk("ovr.q_msb",   32'(bm.q),       32'hA);
        chk("ovr.valid",   32'(bl.valid),   1);
        chk("ovr.overrun", 32'(bl.overrun), 1);
        step(0, 0, 0, 1);
        chk("ovr.sticky",  32'(bl.overrun), 1);

        // Async reset mid-word clears outputs with no clock edge.
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst.q",       32'(bl.q),       0);
        chk("arst.valid",   32'(bl.valid),   0);
        chk("arst.overrun", 32'(bl.overrun), 0);
        chk("arst.busy",    32'(bl.busy),    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(4'hF, 1'b0, 1'b0);
        chk("arst.nosync_valid", 32'(bl.valid), 0);
        chk("arst.nosync_q",     32'(bl.q),     0);
        check_model("arst.model");

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) == 0));
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver that deserializes the LSB-first bit stream produced by the team's parallel-to-serial shifter back into WIDTH-bit words. It sits at the receiving end of the serial link. A frame-alignment input (`sync`) marks word boundaries. The block holds each assembled word with a valid/ack handshake toward the downstream consumer and flags words lost to overrun.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `LSB_FIRST`, default 1: 1 means the first received bit lands in `q[0]`; 0 means it lands in `q[WIDTH-1]`.
- `clk` input 1: single clock; all sampling on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din` input 1: serial data bit; sampled only when `en`=1.
- `en` input 1: bit-valid qualifier; one bit is consumed per cycle with `en`=1.
- `sync` input 1: word-boundary marker; aligns the bit counter.
- `ack` input 1: consumer accepts the held word.
- `q` output WIDTH: last completed word.
- `valid` output 1: `q` holds an unacknowledged word.
- `overrun` output 1: sticky; a completed word overwrote an unacknowledged one.
- `busy` output 1: a word is partially assembled (`SHIFT` with count > 0).

## Operation
- Reset (async assert, sync release) forces the following:
  - state = `HUNT`, bit count = 0, shift register = 0;
  - `q` = 0, `valid` = 0, `overrun` = 0, `busy` = 0.
- State `HUNT`: `din` is ignored until `sync`=1.
  - `sync`=1 with `en`=0: go to `SHIFT` with count = 0.
  - `sync`=1 with `en`=1: that bit is bit 0; go to `SHIFT` with count = 1.
- State `SHIFT`: each cycle with `en`=1 shifts `din` into the register at the next position and increments the count.
- Bit placement:
  - `LSB_FIRST`=1: the k-th received bit (k from 0) goes to position k.
  - `LSB_FIRST`=0: the k-th received bit goes to position WIDTH-1-k.
- Word complete: the cycle the WIDTH-th bit is sampled.
  - The assembled word (including that bit) is written to `q`.
  - `valid` is set and the count returns to 0.
  - State stays `SHIFT`, so back-to-back words need no further `sync`.
- `sync` while in `SHIFT` re-aligns:
  - The partial word is discarded and the count restarts.
  - If `en`=1 in the same cycle, that bit becomes bit 0 (count = 1).
  - `sync` has priority over word completion: on a cycle where `sync`=1 and the count would reach WIDTH, no word is emitted.
- Handshake:
  - `valid` stays high until `ack`=1 is sampled while `valid`=1.
  - `ack` while `valid`=0 is ignored.
  - `q` is stable while `valid`=1, except on overrun.
- Word completion and `ack` in the same cycle: the new word loads, `valid` stays 1, and `overrun` is not set.
- Word completion while `valid`=1 and `ack`=0: `q` is overwritten with the new word, `valid` stays 1, and `overrun` is set. `overrun` clears only on `rst`.
- `busy` = 1 exactly when state = `SHIFT` and count != 0.

## Timing
- Latency: `q`/`valid` update at the clock edge that samples the final bit and are visible in the following cycle.
- Throughput: one word per WIDTH `en` cycles. Gaps in `en` stall assembly without losing alignment.
- `ack` takes effect at the sampling edge; `valid` drops in the next cycle.
- `rst` asserted mid-word clears all state immediately. After reset the block is in `HUNT` and needs `sync` again.
- Count width is clog2(WIDTH+1). No arithmetic wrap: the count always returns to 0 at WIDTH.

## Test plan
- Basic receive (WIDTH=4, LSB_FIRST=1): `sync`+`en` with bits 1,0,1,1 on consecutive cycles → `q`=4'hD, `valid`=1 one cycle after the 4th bit; `ack` → `valid`=0 next cycle.
- MSB-first (LSB_FIRST=0): same bits 1,0,1,1 → `q`=4'hB.
- Hunt and re-align: bits sent before `sync` are ignored. After two bits into a word, `sync`+`en` with bits 0,1,1,0 → `q`=4'h6; the partial word is never emitted.
- Stall: bits 1,1,0,1 with `en` low for 3 cycles between each bit → `q`=4'hB; `busy`=1 throughout the gaps.
- Overrun and simultaneous ack, using back-to-back words 4'h3 then 4'h5:
  - No `ack` → `q`=4'h5, `valid`=1, `overrun`=1.
  - Repeat with `ack` on the completion cycle of the second word → `q`=4'h5, `valid`=1, `overrun`=0.
- Async reset mid-word: assert `rst` after 2 bits → all outputs 0 without a clock edge. After release, a word sent without `sync` is ignored.
